// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W       = 64;
    localparam int MEM_ARB_DATA_W       = 64;
    localparam int MEM_ARB_STARVE_LIMIT = 4;
    localparam int MEM_ARB_STARVE_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters; data wins unless fetch is starved.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether a grant is taken this cycle.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic                        if_vld,
    input  logic                        d_vld,
    input  logic [MEM_ARB_STARVE_W-1:0] starve_cnt,
    input  logic [MEM_ARB_STARVE_W-1:0] starve_limit,
    output arb_owner_t                  gnt_owner,
    output logic                        gnt_vld
);

    logic if_wins;

    assign if_wins   = if_vld && (!d_vld || (starve_cnt == starve_limit));
    assign gnt_owner = if_wins ? OWN_IF : OWN_D;
    assign gnt_vld   = if_vld || d_vld;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one variable-latency memory port.
// Latency: accept -> mem_req next cycle; mem_ack -> response pulse next cycle (3 cycles min).
// Backpressure: readies only in IDLE; mem_req held with stable fields until mem_ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = MEM_ARB_ADDR_W,
    parameter int DATA_W       = MEM_ARB_DATA_W,
    parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic [63:0]         stall_cycles
);

    localparam logic [MEM_ARB_STARVE_W-1:0] LIMIT = MEM_ARB_STARVE_W'(STARVE_LIMIT);

    arb_state_t                  state;
    arb_owner_t                  owner;
    arb_owner_t                  gnt_owner;
    logic                        gnt_vld;
    logic                        accept;
    logic [MEM_ARB_STARVE_W-1:0] starve_cnt;

    mem_arb_pick u_pick (
        .if_vld       (if_req_valid),
        .d_vld        (d_req_valid),
        .starve_cnt   (starve_cnt),
        .starve_limit (LIMIT),
        .gnt_owner    (gnt_owner),
        .gnt_vld      (gnt_vld)
    );

    assign accept       = (state == IDLE) && gnt_vld;
    assign if_req_ready = accept && (gnt_owner == OWN_IF);
    assign d_req_ready  = accept && (gnt_owner == OWN_D);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            starve_cnt    <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
        end else begin
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= gnt_owner;
                        mem_req <= 1'b1;
                        state   <= WAIT;
                        if (gnt_owner == OWN_IF) begin
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            mem_wdata  <= '0;
                            mem_wstrb  <= '0;
                            starve_cnt <= '0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_wstrb;
                            // Only a data grant that overtook a waiting fetch counts toward starvation.
                            if (!if_req_valid)
                                starve_cnt <= '0;
                            else if (starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (owner == OWN_IF) begin
                            if_resp_data  <= mem_rdata;
                            if_resp_valid <= 1'b1;
                        end else begin
                            d_resp_data  <= mem_we ? '0 : mem_rdata;
                            d_resp_valid <= 1'b1;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if ((if_req_valid && !if_req_ready) || (d_req_valid && !d_req_ready))
            stall_cycles <= stall_cycles + 64'd1;
    end

endmodule
